// File: rtl/dtack_wait_state_controller_if.sv
// rtl/dtack_wait_state_controller_if.sv - CPU/decoder/device handshake bundle for the DTACK sequencer
`timescale 1ns/1ps
interface dtack_wait_state_controller_if;
    logic AS_L;
    logic CanBusSelect_H;
    logic CanBusDtack_L;
    logic DramSelect_H;
    logic DramDtack_L;
    logic FlashSelect_H;
    logic SlowIOSelect_H;
    logic ClearTimeout_H;
    logic DtackOut_L;
    logic BErrOut_L;
    logic TimeoutFlag_H;
    logic Busy_H;

    modport master (
        output AS_L, CanBusSelect_H, CanBusDtack_L, DramSelect_H, DramDtack_L,
               FlashSelect_H, SlowIOSelect_H, ClearTimeout_H,
        input  DtackOut_L, BErrOut_L, TimeoutFlag_H, Busy_H
    );

    modport slave (
        input  AS_L, CanBusSelect_H, CanBusDtack_L, DramSelect_H, DramDtack_L,
               FlashSelect_H, SlowIOSelect_H, ClearTimeout_H,
        output DtackOut_L, BErrOut_L, TimeoutFlag_H, Busy_H
    );
endinterface

// File: rtl/dtack_wait_state_controller.sv
// rtl/dtack_wait_state_controller.sv - registered DTACK/BERR sequencer for the 68k bus
`timescale 1ns/1ps
module dtack_wait_state_controller #(
    parameter int FLASH_WAIT     = 4,
    parameter int IO_WAIT        = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 8
) (
    input  logic Clock,
    input  logic Reset_H,
    dtack_wait_state_controller_if.slave bus
);

    typedef enum logic [2:0] {IDLE, WAIT_CNT, WAIT_EXT, ACK, BERR} state_t;

    localparam logic [CNT_W-1:0] FLASH_N      = CNT_W'(FLASH_WAIT);
    localparam logic [CNT_W-1:0] IO_N         = CNT_W'(IO_WAIT);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] ONE          = CNT_W'(1);

    state_t           state;
    logic [CNT_W-1:0] waitCnt;
    logic [CNT_W-1:0] ageCnt;
    logic             extIsDram;
    logic             extDtack_L;
    logic             dtackReg;
    logic             berrReg;
    logic             flagReg;
    logic             busyReg;

    // Only the device latched at cycle start may acknowledge.
    assign extDtack_L = extIsDram ? bus.DramDtack_L : bus.CanBusDtack_L;

    assign bus.DtackOut_L    = dtackReg;
    assign bus.BErrOut_L     = berrReg;
    assign bus.TimeoutFlag_H = flagReg;
    assign bus.Busy_H        = busyReg;

    always_ff @(posedge Clock or posedge Reset_H) begin
        if (Reset_H) begin
            state     <= IDLE;
            waitCnt   <= '0;
            ageCnt    <= '0;
            extIsDram <= 1'b0;
            dtackReg  <= 1'b1;
            berrReg   <= 1'b1;
            flagReg   <= 1'b0;
            busyReg   <= 1'b0;
        end else begin
            // Clear first so a BERR entry on the same edge overrides it.
            if (bus.ClearTimeout_H) flagReg <= 1'b0;

            case (state)
                IDLE: begin
                    if (!bus.AS_L) begin
                        ageCnt  <= '0;
                        busyReg <= 1'b1;
                        if (bus.CanBusSelect_H) begin
                            extIsDram <= 1'b0;
                            state     <= WAIT_EXT;
                        end else if (bus.DramSelect_H) begin
                            extIsDram <= 1'b1;
                            state     <= WAIT_EXT;
                        end else if (bus.FlashSelect_H) begin
                            waitCnt <= FLASH_N;
                            state   <= (FLASH_WAIT == 0) ? ACK : WAIT_CNT;
                        end else if (bus.SlowIOSelect_H) begin
                            waitCnt <= IO_N;
                            state   <= (IO_WAIT == 0) ? ACK : WAIT_CNT;
                        end else begin
                            state <= ACK;
                        end
                    end
                end

                WAIT_CNT: begin
                    if (bus.AS_L) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        ageCnt <= ageCnt + ONE;
                        if (waitCnt <= ONE) begin
                            state <= ACK;
                        end else if (ageCnt == TIMEOUT_LAST) begin
                            state   <= BERR;
                            berrReg <= 1'b0;
                            flagReg <= 1'b1;
                        end else begin
                            waitCnt <= waitCnt - ONE;
                        end
                    end
                end

                WAIT_EXT: begin
                    if (bus.AS_L) begin
                        state   <= IDLE;
                        busyReg <= 1'b0;
                    end else begin
                        ageCnt <= ageCnt + ONE;
                        // Acknowledge is tested before timeout so it wins a tie.
                        if (!extDtack_L) begin
                            state    <= ACK;
                            dtackReg <= 1'b0;
                        end else if (ageCnt == TIMEOUT_LAST) begin
                            state   <= BERR;
                            berrReg <= 1'b0;
                            flagReg <= 1'b1;
                        end
                    end
                end

                ACK: begin
                    if (bus.AS_L) begin
                        state    <= IDLE;
                        dtackReg <= 1'b1;
                        busyReg  <= 1'b0;
                    end else begin
                        dtackReg <= 1'b0;
                    end
                end

                BERR: begin
                    if (bus.AS_L) begin
                        state   <= IDLE;
                        berrReg <= 1'b1;
                        busyReg <= 1'b0;
                    end
                end

                default: begin
                    state    <= IDLE;
                    dtackReg <= 1'b1;
                    berrReg  <= 1'b1;
                    busyReg  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dtack_wait_state_controller.sv
// tb/tb_dtack_wait_state_controller.sv - randomized and directed checks against a cycle-age model
`timescale 1ns/1ps
module tb_dtack_wait_state_controller;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic asL = 1'b1, can = 1'b0, dram = 1'b0, flash = 1'b0, slow = 1'b0;
    logic canDt = 1'b1, dramDt = 1'b1, clr = 1'b0;

    dtack_wait_state_controller_if bus0 ();
    dtack_wait_state_controller_if bus1 ();

    assign bus0.AS_L = asL;            assign bus1.AS_L = asL;
    assign bus0.CanBusSelect_H = can;  assign bus1.CanBusSelect_H = can;
    assign bus0.CanBusDtack_L = canDt; assign bus1.CanBusDtack_L = canDt;
    assign bus0.DramSelect_H = dram;   assign bus1.DramSelect_H = dram;
    assign bus0.DramDtack_L = dramDt;  assign bus1.DramDtack_L = dramDt;
    assign bus0.FlashSelect_H = flash; assign bus1.FlashSelect_H = flash;
    assign bus0.SlowIOSelect_H = slow; assign bus1.SlowIOSelect_H = slow;
    assign bus0.ClearTimeout_H = clr;  assign bus1.ClearTimeout_H = clr;

    dtack_wait_state_controller dut0 (
        .Clock(clk), .Reset_H(rst), .bus(bus0.slave)
    );

    dtack_wait_state_controller #(
        .FLASH_WAIT(0), .IO_WAIT(19), .TIMEOUT_CYCLES(20), .CNT_W(5)
    ) dut1 (
        .Clock(clk), .Reset_H(rst), .bus(bus1.slave)
    );

    logic dtOut [2];
    logic beOut [2];
    logic flOut [2];
    logic bsOut [2];
    assign dtOut[0] = bus0.DtackOut_L;    assign dtOut[1] = bus1.DtackOut_L;
    assign beOut[0] = bus0.BErrOut_L;     assign beOut[1] = bus1.BErrOut_L;
    assign flOut[0] = bus0.TimeoutFlag_H; assign flOut[1] = bus1.TimeoutFlag_H;
    assign bsOut[0] = bus0.Busy_H;        assign bsOut[1] = bus1.Busy_H;

    int passCount = 0;
    int totalCount = 0;

    task automatic chk(input string name, input logic act, input logic exp);
        totalCount++;
        if (act === exp) passCount++;
        else $display("FAIL %s: got %b, expected %b at %0t", name, act, exp, $time);
    endtask

    // Model: a cycle is described by its age in edges since the start edge,
    // the device kind latched at start, and whether it has acked or errored.
    int paramWait [2] = '{0, 0};
    int flashWait [2] = '{4, 0};
    int ioWait    [2] = '{2, 19};
    int timeout   [2] = '{255, 20};

    bit mInCycle [2];
    int mAge     [2];
    int mWait    [2];
    bit mExt     [2];
    bit mDram    [2];
    bit mAcked   [2];
    bit mBerr    [2];
    bit mFlag    [2];

    initial begin
        for (int i = 0; i < 2; i++) begin
            mInCycle[i] = 0; mAcked[i] = 0; mBerr[i] = 0; mFlag[i] = 0;
            mAge[i] = 0; mWait[i] = 0; mExt[i] = 0; mDram[i] = 0;
        end
        forever begin
            @(posedge clk or posedge rst);
            for (int i = 0; i < 2; i++) begin
                if (rst) begin
                    mInCycle[i] = 0; mAcked[i] = 0; mBerr[i] = 0; mFlag[i] = 0;
                end else begin
                    bit setFlag;
                    setFlag = 0;
                    if (!mInCycle[i]) begin
                        if (!asL) begin
                            mInCycle[i] = 1; mAge[i] = 0; mAcked[i] = 0; mBerr[i] = 0;
                            mExt[i] = can || dram;
                            mDram[i] = !can && dram;
                            mWait[i] = flash ? flashWait[i] : (slow ? ioWait[i] : 0);
                        end
                    end else if (asL) begin
                        mInCycle[i] = 0;
                    end else begin
                        mAge[i]++;
                        if (!mAcked[i] && !mBerr[i]) begin
                            if (mExt[i] ? ((mDram[i] ? dramDt : canDt) == 1'b0)
                                        : (mAge[i] >= mWait[i] + 1))
                                mAcked[i] = 1;
                            else if (mAge[i] == timeout[i]) begin
                                mBerr[i] = 1;
                                setFlag = 1;
                            end
                        end
                    end
                    if (setFlag) mFlag[i] = 1;
                    else if (clr) mFlag[i] = 0;
                end
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            for (int i = 0; i < 2; i++) begin
                chk($sformatf("dtack[%0d]", i), dtOut[i], !(mInCycle[i] && mAcked[i]));
                chk($sformatf("berr[%0d]", i), beOut[i], !(mInCycle[i] && mBerr[i]));
                chk($sformatf("flag[%0d]", i), flOut[i], mFlag[i]);
                chk($sformatf("busy[%0d]", i), bsOut[i], mInCycle[i]);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic randomSelects();
        if ($urandom_range(0, 3) == 0) {can, dram, flash, slow} = 4'b0000;
        else {can, dram, flash, slow} = 4'($urandom_range(0, 15));
    endtask

    task automatic randomCycle(input int maxLen);
        int len, dCan, dDram;
        randomSelects();
        len   = $urandom_range(1, maxLen);
        dCan  = $urandom_range(1, maxLen + 5);
        dDram = $urandom_range(1, maxLen + 5);
        asL = 1'b0;
        step();
        for (int j = 1; j <= len; j++) begin
            canDt  = (j < dCan);
            dramDt = (j < dDram);
            if ($urandom_range(0, 3) == 0) randomSelects();
            clr = ($urandom_range(0, 15) == 0);
            step();
        end
        asL = 1'b1; canDt = 1'b1; dramDt = 1'b1;
        clr = 1'($urandom_range(0, 1));
        step();
        clr = 1'b0;
        repeat ($urandom_range(0, 2)) step();
    endtask

    initial begin
        #12;
        chk("reset dtack", bus0.DtackOut_L, 1'b1);
        chk("reset berr", bus0.BErrOut_L, 1'b1);
        chk("reset flag", bus0.TimeoutFlag_H, 1'b0);
        chk("reset busy", bus0.Busy_H, 1'b0);
        step();
        rst = 1'b0;
        step();

        // Default access: DTACK from k+1, released on the edge AS_L is seen high
        asL = 1'b0; step();
        chk("default busy k", bus0.Busy_H, 1'b1);
        chk("default dtack k", bus0.DtackOut_L, 1'b1);
        step();
        chk("default dtack k+1", bus0.DtackOut_L, 1'b0);
        step(); step(); step();
        asL = 1'b1; step();
        chk("default release dtack", bus0.DtackOut_L, 1'b1);
        chk("default release busy", bus0.Busy_H, 1'b0);
        step();

        // Flash: 4 waits on dut0 (DTACK from k+5), 0 waits on dut1 (from k+1)
        flash = 1'b1; asL = 1'b0; step();
        step();
        chk("flash0 dtack k+1 dut1", bus1.DtackOut_L, 1'b0);
        step(); step(); step();
        chk("flash4 dtack k+4", bus0.DtackOut_L, 1'b1);
        step();
        chk("flash4 dtack k+5", bus0.DtackOut_L, 1'b0);
        flash = 1'b0; asL = 1'b1; step(); step();

        // CAN beats DRAM; DRAM's ack is ignored
        can = 1'b1; dram = 1'b1; canDt = 1'b1; dramDt = 1'b0; asL = 1'b0; step();
        can = 1'b0; dram = 1'b0;
        repeat (5) step();
        chk("can priority no dtack", bus0.DtackOut_L, 1'b1);
        canDt = 1'b0; step();
        chk("can dtack same edge", bus0.DtackOut_L, 1'b0);
        asL = 1'b1; canDt = 1'b1; dramDt = 1'b1; step(); step();

        // DRAM timeout at k+255
        dram = 1'b1; asL = 1'b0; step();
        dram = 1'b0;
        repeat (254) step();
        chk("timeout berr k+254", bus0.BErrOut_L, 1'b1);
        step();
        chk("timeout berr k+255", bus0.BErrOut_L, 1'b0);
        chk("timeout flag set", bus0.TimeoutFlag_H, 1'b1);
        chk("timeout no dtack", bus0.DtackOut_L, 1'b1);
        asL = 1'b1; step();
        chk("timeout berr release", bus0.BErrOut_L, 1'b1);
        chk("timeout flag sticky", bus0.TimeoutFlag_H, 1'b1);
        step();
        clr = 1'b1; step();
        chk("timeout flag cleared", bus0.TimeoutFlag_H, 1'b0);
        clr = 1'b0; step();

        // Ack on the timeout edge wins
        dram = 1'b1; asL = 1'b0; step();
        dram = 1'b0;
        repeat (254) step();
        dramDt = 1'b0; step();
        chk("tie dtack wins", bus0.DtackOut_L, 1'b0);
        chk("tie no berr", bus0.BErrOut_L, 1'b1);
        chk("tie no flag", bus0.TimeoutFlag_H, 1'b0);
        asL = 1'b1; dramDt = 1'b1; step(); step();

        // Aborted slow IO cycle, then a normal one
        slow = 1'b1; asL = 1'b0; step();
        asL = 1'b1; slow = 1'b0; step();
        chk("abort busy", bus0.Busy_H, 1'b0);
        chk("abort dtack", bus0.DtackOut_L, 1'b1);
        chk("abort berr", bus0.BErrOut_L, 1'b1);
        step();
        asL = 1'b0; step();
        chk("after abort busy", bus0.Busy_H, 1'b1);
        step();
        chk("after abort dtack", bus0.DtackOut_L, 1'b0);
        asL = 1'b1; step(); step();

        // Reset two edges into a Flash wait, AS_L held low across it
        flash = 1'b1; asL = 1'b0; step(); step(); step();
        chk("pre-reset busy", bus0.Busy_H, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("mid reset dtack", bus0.DtackOut_L, 1'b1);
        chk("mid reset berr", bus0.BErrOut_L, 1'b1);
        chk("mid reset busy", bus0.Busy_H, 1'b0);
        #2 rst = 1'b0;
        step();
        chk("post reset restart busy", bus0.Busy_H, 1'b1);
        repeat (4) step();
        chk("post reset dtack k+4", bus0.DtackOut_L, 1'b1);
        step();
        chk("post reset dtack k+5", bus0.DtackOut_L, 1'b0);
        flash = 1'b0; asL = 1'b1; step(); step();

        repeat (60) randomCycle(30);
        repeat (4) randomCycle(300);
        {can, dram, flash, slow} = 4'b0000;
        asL = 1'b1;
        step(); step();

        $display("%0d/%0d checks passed", passCount, totalCount);
        $finish;
    end

endmodule

// File: doc/dtack_wait_state_controller.md
Name: dtack_wait_state_controller

Overview:
- Registered DTACK/BERR sequencer for the 68k bus. It replaces purely combinational DTACK generation with a small state machine.
- Per cycle it does one of four things: acknowledge fast devices after one clock; insert a fixed count of wait states for Flash and slow IO; relay handshakes from the DRAM and CAN controllers; or raise bus error if no acknowledge arrives within a timeout.
- Sits between the address decoder / device controllers and the CPU DTACK_L and BERR_L pins.

Parameters:
- FLASH_WAIT, 4, wait states inserted for Flash accesses (0..TIMEOUT_CYCLES-1)
- IO_WAIT, 2, wait states inserted for slow IO accesses (0..TIMEOUT_CYCLES-1)
- TIMEOUT_CYCLES, 255, clocks from cycle start to bus error when no acknowledge arrives
- CNT_W, 8, counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
- Clock  in  1  system clock; all state changes on its rising edge
- Reset_H  in  1  asynchronous active-high reset
- AS_L  in  1  68k address strobe; same clock domain, sampled directly
- CanBusSelect_H  in  1  address decoder: CAN controller selected
- CanBusDtack_L  in  1  handshake from the CAN controller
- DramSelect_H  in  1  address decoder: DRAM selected
- DramDtack_L  in  1  handshake from the DRAM controller
- FlashSelect_H  in  1  address decoder: Flash selected
- SlowIOSelect_H  in  1  address decoder: slow IO selected
- ClearTimeout_H  in  1  clears TimeoutFlag_H
- DtackOut_L  out  1  registered DTACK to the CPU
- BErrOut_L  out  1  registered bus error to the CPU
- TimeoutFlag_H  out  1  sticky flag: a bus error has occurred
- Busy_H  out  1  high whenever the FSM is not in IDLE

Behaviour:
- Reset (asynchronous): state=IDLE, counters=0, DtackOut_L=1, BErrOut_L=1, TimeoutFlag_H=0, Busy_H=0. Takes effect immediately, including mid-cycle.
- Timing notation: "edge k" is the first rising edge at which AS_L is sampled 0 while in IDLE. Selects are sampled at edge k and latched for the whole cycle; select changes after edge k are ignored.
- Select priority at edge k: CanBus > Dram > Flash > SlowIO > default (no select).
- States: IDLE, WAIT_CNT, WAIT_EXT, ACK, BERR.
- IDLE transitions at edge k:
  - default -> ACK.
  - Flash/SlowIO with N=FLASH_WAIT/IO_WAIT: N=0 -> ACK; N>0 -> WAIT_CNT with wait counter = N.
  - CanBus/Dram -> WAIT_EXT.
  - Cycle-age counter cleared to 0.
- Default cycle: DtackOut_L=0 from edge k+1.
- WAIT_CNT: wait counter decrements each edge; ACK is entered so that DtackOut_L=0 from edge k+1+N.
- WAIT_EXT: the selected external dtack (only the latched device's) is sampled each edge. The first edge at which it is 0 moves to ACK, so DtackOut_L=0 from that edge. The earliest possible is edge k+1, if the external dtack is already low at edge k+1.
- Cycle-age counter: increments every edge in WAIT_CNT/WAIT_EXT. If no acknowledge has occurred, BERR is entered so that BErrOut_L=0 from edge k+TIMEOUT_CYCLES and TimeoutFlag_H=1. DtackOut_L stays 1 in BERR.
- Acknowledge and timeout on the same edge: the acknowledge wins (ACK, no BERR).
- ACK and BERR: hold outputs until AS_L is sampled 1. Then go to IDLE with DtackOut_L=1 and BErrOut_L=1 from that same edge. DtackOut_L and BErrOut_L are never 0 together.
- Aborted cycle: AS_L sampled 1 in WAIT_CNT/WAIT_EXT -> IDLE, no DTACK, no BERR, flag unchanged.
- Back-to-back cycles: a new cycle starts only from IDLE, so AS_L must be seen high for at least one edge between cycles.
- TimeoutFlag_H: set on BERR entry, cleared by ClearTimeout_H. Set wins if both occur on the same edge.
- Busy_H = (state != IDLE), registered.

Test Plan:
- Reset asserted mid-WAIT_CNT (Flash, 2 edges in) -> DtackOut_L=1, BErrOut_L=1, Busy_H=0 immediately. After release, AS_L still low is treated as a new cycle start.
- Default access (no select), AS_L low at edge 10 -> DtackOut_L=0 from edge 11. AS_L high at edge 14 -> DtackOut_L=1 from edge 14.
- Flash access, FLASH_WAIT=4, AS_L low at edge 10 -> DtackOut_L=0 from edge 15. Repeat with FLASH_WAIT=0 -> DtackOut_L=0 from edge 11.
- DRAM and CAN both selected with CanBusDtack_L held 1 and DramDtack_L=0 -> CAN wins, no DTACK. CanBusDtack_L low at edge 20 -> DtackOut_L=0 from edge 20.
- DRAM select with DramDtack_L stuck at 1, TIMEOUT_CYCLES=255, start edge 10 -> BErrOut_L=0 from edge 265 and TimeoutFlag_H=1. Flag persists after AS_L rises and clears on ClearTimeout_H. Repeat with DramDtack_L low at exactly edge 265 -> DTACK, no BERR.
- SlowIO with IO_WAIT=2, AS_L raised at edge k+1 -> IDLE, no DTACK/BERR. Next cycle runs normally.
